cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Moore control unit that sequences the single-bus datapath through instruction fetch (T0–T2) and execute (T3–T6) for register-register ALU, unary ALU and multiply/divide instructions.
- Replaces the hand-driven control strobes used in datapath benches today.
- Sits beside the datapath. It reads IR and drives every bus-source, register-load, ALU-control and memory-read strobe, plus the Gra/Grb/Grc/R_In/R_Out select signals consumed by the datapath's register-select logic.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- IRW, 32, instruction register width.

Ports:
- Clock  in  1  system clock, all state changes on rising edge
- Clear  in  1  asynchronous active-low reset
- IR  in  32  instruction register contents from datapath
- Start  in  1  leave IDLE and begin fetching
- Mem_Ready  in  1  memory read data valid this cycle
- PC_Out, ZHI_Out, ZLO_Out, MDR_Out  out  1 each  bus source enables
- MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In, HI_In, LO_In  out  1 each  register load enables
- IncPC  out  1  ALU computes PC+1
- Read  out  1  memory read strobe / MDR mux select
- Gra, Grb, Grc  out  1 each  select IR ra/rb/rc field for register access
- R_In, R_Out  out  1 each  load / drive the selected general register
- CONTROL  out  5  ALU operation code
- Running  out  1  high in any fetch/execute state
- Halted  out  1  high in HALT
- Illegal  out  1  sticky: unrecognised opcode executed since reset

Behaviour:
- Encoding:
  - op = IR[31:27], ra = IR[26:23], rb = IR[22:19], rc = IR[18:15].
  - R-type: op 0x00–0x0A (add, sub, and, or, shr, shra, shl, ror, rol, sll, srl).
  - MULDIV: 0x0E mul, 0x0F div.
  - UNARY: 0x10 neg, 0x11 not.
  - NOP: 0x1A. HALT: 0x1B. All other opcodes are illegal.
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT. Outputs decode from the state register (plus op in T3–T6) only. No Mealy paths.
- Reset: Clear low → state IDLE immediately. All outputs 0, including Illegal, Halted and Running. This applies even mid-instruction, and strobes drop asynchronously.
- IDLE: outputs 0. Move to T0 when Start = 1 at a rising edge.
- T0: PC_Out, MAR_In, IncPC, Z_In. → T1.
- T1: ZLO_Out, PC_In, Read, MDR_In.
  - → T2 if Mem_Ready = 1, else → T1W.
- T1W: Read, MDR_In only (no PC_In).
  - Hold until Mem_Ready = 1, then → T2. Wait is unbounded.
- T2: MDR_Out, IR_In. → T3.
- T3 by class:
  - R-type, MULDIV: Grb, R_Out, Y_In.
  - UNARY: Grb, R_Out, Z_In, CONTROL = op.
  - NOP: no strobes, → T0.
  - HALT: → HALT.
  - Illegal: set Illegal, → T0.
- T4 by class:
  - R-type, MULDIV: Grc, R_Out, Z_In, CONTROL = op.
  - UNARY: ZLO_Out, Gra, R_In, → T0.
- T5 by class:
  - R-type: ZLO_Out, Gra, R_In, → T0.
  - MULDIV: ZLO_Out, LO_In, → T6.
- T6 (MULDIV only): ZHI_Out, HI_In. → T0.
- CONTROL is 0 in every state other than those listed.
- At most one bus-source enable is high in any cycle. Checked by assertion in the bench.
- Latency from T0 with no memory wait:
  - R-type: 6 cycles.
  - MULDIV: 7 cycles.
  - UNARY: 5 cycles.
  - NOP, illegal: 4 cycles.
  - Each T1W cycle adds 1.
- HALT: Halted = 1, Running = 0, all strobes 0. Stays in HALT regardless of Start; only Clear exits.
- Illegal stays set until Clear. Start asserted while running is ignored.

Test Plan:
- Reset and start: Clear low for 2 cycles, Start = 0 → IDLE, all outputs 0 for 5 cycles. Then Start = 1 → T0 next edge with PC_Out = MAR_In = IncPC = Z_In = 1.
- add R5,R2,R4: IR = 0x02920000, Mem_Ready tied 1 → exact 6-cycle strobe sequence T0–T5. CONTROL = 00000 only in T4. Gra & R_In in T5. Returns to T0.
- neg R5,R2: IR = 0x82900000 → T3 has Grb, R_Out, Z_In, CONTROL = 10000. T4 has ZLO_Out, Gra, R_In. 5 cycles total.
- mul R3,R1 with memory wait: IR = 0x70188000, Mem_Ready low for 3 cycles after T1 → 3 T1W cycles with Read = MDR_In = 1 and PC_In = 0. Then T2–T6 with LO_In in T5 and HI_In in T6.
- Illegal then halt: IR = 0xA8000000 → Illegal rises at T3 and fetch continues at T0. Next IR = 0xD8000000 → HALT, Halted = 1. Start pulses are ignored and Illegal stays 1.
- Reset mid-instruction: Clear low during T4 of add → all strobes 0 within the same cycle and state IDLE. After release, Start restarts cleanly at T0.

Source files
------------

// File: rtl/cpu_control_sequencer.sv
// Moore control sequencer for the single-bus datapath: fetch (T0-T2, with T1W memory wait)
// followed by execute (T3-T6) for R-type, unary and multiply/divide instructions.
module cpu_control_sequencer #(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [IRW-1:0] IR,
  input  logic           Start,
  input  logic           Mem_Ready,
  output logic           PC_Out,
  output logic           ZHI_Out,
  output logic           ZLO_Out,
  output logic           MDR_Out,
  output logic           MAR_In,
  output logic           PC_In,
  output logic           MDR_In,
  output logic           IR_In,
  output logic           Y_In,
  output logic           Z_In,
  output logic           HI_In,
  output logic           LO_In,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           R_In,
  output logic           R_Out,
  output logic [4:0]     CONTROL,
  output logic           Running,
  output logic           Halted,
  output logic           Illegal
);

  typedef enum logic [3:0] {IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT} state_t;

  state_t         state, next_state;
  logic           illegal_q;
  logic [OPW-1:0] op;
  logic           is_rtype, is_muldiv, is_unary, is_nop, is_halt, is_illegal;

  // Register fields are decoded by the datapath's select logic, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[IRW-OPW-1:0];

  assign op         = IR[IRW-1 -: OPW];
  assign is_rtype   = (op <= OPW'(10));
  assign is_muldiv  = (op == OPW'(14)) || (op == OPW'(15));
  assign is_unary   = (op == OPW'(16)) || (op == OPW'(17));
  assign is_nop     = (op == OPW'(26));
  assign is_halt    = (op == OPW'(27));
  assign is_illegal = !(is_rtype || is_muldiv || is_unary || is_nop || is_halt);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state     <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == T3 && is_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    PC_Out  = 1'b0; ZHI_Out = 1'b0; ZLO_Out = 1'b0; MDR_Out = 1'b0;
    MAR_In  = 1'b0; PC_In   = 1'b0; MDR_In  = 1'b0; IR_In   = 1'b0;
    Y_In    = 1'b0; Z_In    = 1'b0; HI_In   = 1'b0; LO_In   = 1'b0;
    IncPC   = 1'b0; Read    = 1'b0;
    Gra     = 1'b0; Grb     = 1'b0; Grc     = 1'b0;
    R_In    = 1'b0; R_Out   = 1'b0;
    CONTROL = 5'd0;
    Running = (state != IDLE) && (state != HALT);
    Halted  = (state == HALT);
    Illegal = illegal_q;

    unique case (state)
      IDLE: if (Start) next_state = T0;
      T0: begin
        PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; Z_In = 1'b1;
        next_state = T1;
      end
      T1: begin
        ZLO_Out = 1'b1; PC_In = 1'b1; Read = 1'b1; MDR_In = 1'b1;
        next_state = Mem_Ready ? T2 : T1W;
      end
      // PC was already updated in T1, so the wait state only keeps the read alive.
      T1W: begin
        Read = 1'b1; MDR_In = 1'b1;
        if (Mem_Ready) next_state = T2;
      end
      T2: begin
        MDR_Out = 1'b1; IR_In = 1'b1;
        next_state = T3;
      end
      T3: begin
        if (is_rtype || is_muldiv) begin
          Grb = 1'b1; R_Out = 1'b1; Y_In = 1'b1;
          next_state = T4;
        end else if (is_unary) begin
          Grb = 1'b1; R_Out = 1'b1; Z_In = 1'b1; CONTROL = 5'(op);
          next_state = T4;
        end else if (is_halt) begin
          next_state = HALT;
        end else begin
          Illegal = illegal_q | is_illegal;
          next_state = T0;
        end
      end
      T4: begin
        if (is_unary) begin
          ZLO_Out = 1'b1; Gra = 1'b1; R_In = 1'b1;
          next_state = T0;
        end else begin
          Grc = 1'b1; R_Out = 1'b1; Z_In = 1'b1; CONTROL = 5'(op);
          next_state = T5;
        end
      end
      T5: begin
        ZLO_Out = 1'b1;
        if (is_muldiv) begin
          LO_In = 1'b1;
          next_state = T6;
        end else begin
          Gra = 1'b1; R_In = 1'b1;
          next_state = T0;
        end
      end
      T6: begin
        ZHI_Out = 1'b1; HI_In = 1'b1;
        next_state = T0;
      end
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: directed scenarios then random instructions,
// each compared cycle by cycle against a strobe list built from the instruction class.
module tb_cpu_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] IR = 32'd0;
  logic        Start = 1'b0;
  logic        Mem_Ready = 1'b0;
  logic PC_Out, ZHI_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In;
  logic Y_In, Z_In, HI_In, LO_In, IncPC, Read, Gra, Grb, Grc, R_In, R_Out;
  logic [4:0] CONTROL;
  logic Running, Halted, Illegal;

  cpu_control_sequencer #(.OPW(5), .IRW(32)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Start(Start), .Mem_Ready(Mem_Ready),
    .PC_Out(PC_Out), .ZHI_Out(ZHI_Out), .ZLO_Out(ZLO_Out), .MDR_Out(MDR_Out),
    .MAR_In(MAR_In), .PC_In(PC_In), .MDR_In(MDR_In), .IR_In(IR_In),
    .Y_In(Y_In), .Z_In(Z_In), .HI_In(HI_In), .LO_In(LO_In),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .R_In(R_In), .R_Out(R_Out), .CONTROL(CONTROL),
    .Running(Running), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  // Strobe masks, packed in the same order as the observed vector below.
  localparam logic [23:0] PCO = 24'h800000, ZHO = 24'h400000, ZLO = 24'h200000, MDRO = 24'h100000;
  localparam logic [23:0] MARI = 24'h080000, PCI = 24'h040000, MDRI = 24'h020000, IRI = 24'h010000;
  localparam logic [23:0] YI = 24'h008000, ZI = 24'h004000, HII = 24'h002000, LOI = 24'h001000;
  localparam logic [23:0] INC = 24'h000800, RD = 24'h000400, GA = 24'h000200, GB = 24'h000100;
  localparam logic [23:0] GC = 24'h000080, RIN = 24'h000040, ROUT = 24'h000020;

  int   test_cnt = 0;
  int   fail_cnt = 0;
  logic ill_seen = 1'b0;
  logic [23:0] obs;

  assign obs = {PC_Out, ZHI_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In,
                Y_In, Z_In, HI_In, LO_In, IncPC, Read, Gra, Grb, Grc, R_In, R_Out, CONTROL};

  always @(negedge Clock) begin
    test_cnt++;
    assert ($onehot0({PC_Out, ZHI_Out, ZLO_Out, MDR_Out})) else begin
      fail_cnt++;
      $error("FAIL bus_onehot observed=%b expected=at most one set",
             {PC_Out, ZHI_Out, ZLO_Out, MDR_Out});
    end
  end

  task automatic check_output(input string tag, input logic [26:0] want);
    test_cnt++;
    assert ({obs, Running, Halted, Illegal} === want) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, {obs, Running, Halted, Illegal}, want);
    end
  endtask

  task automatic do_reset();
    Clear = 1'b0;
    Start = 1'b0;
    ill_seen = 1'b0;
    repeat (2) @(posedge Clock);
    #1 check_output("reset_hold", 27'd0);
    Clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      check_output($sformatf("idle_%0d", i), 27'd0);
    end
  endtask

  task automatic start_fetch();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  // Expected strobes come straight from the instruction class; aborting pulls Clear mid-cycle.
  task automatic apply_stimulus(input string name, input logic [31:0] ir, input int waits,
                                input int abort_at, output logic halted);
    logic [23:0] exp_q[$];
    logic [4:0]  op;
    logic        bad;
    op = ir[31:27];
    bad = 1'b0;
    halted = 1'b0;
    exp_q.push_back(PCO | MARI | INC | ZI);
    exp_q.push_back(ZLO | PCI | RD | MDRI);
    for (int w = 0; w < waits; w++) exp_q.push_back(RD | MDRI);
    exp_q.push_back(MDRO | IRI);
    if (op <= 5'd10) begin
      exp_q.push_back(GB | ROUT | YI);
      exp_q.push_back(GC | ROUT | ZI | 24'(op));
      exp_q.push_back(ZLO | GA | RIN);
    end else if (op == 5'd14 || op == 5'd15) begin
      exp_q.push_back(GB | ROUT | YI);
      exp_q.push_back(GC | ROUT | ZI | 24'(op));
      exp_q.push_back(ZLO | LOI);
      exp_q.push_back(ZHO | HII);
    end else if (op == 5'd16 || op == 5'd17) begin
      exp_q.push_back(GB | ROUT | ZI | 24'(op));
      exp_q.push_back(ZLO | GA | RIN);
    end else begin
      exp_q.push_back(24'd0);
      halted = (op == 5'd27);
      bad = (op != 5'd26) && (op != 5'd27);
    end
    IR = ir;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= 1 && i <= 1 + waits) Mem_Ready = (i == 1 + waits);
      else Mem_Ready = 1'($urandom_range(0, 1));
      Start = 1'($urandom_range(0, 1));
      if (i == 3 + waits && bad) ill_seen = 1'b1;
      check_output($sformatf("%s_c%0d", name, i), {exp_q[i], 1'b1, 1'b0, ill_seen});
      if (i == abort_at) begin
        Clear = 1'b0;
        #1 check_output($sformatf("%s_async_clear", name), 27'd0);
        ill_seen = 1'b0;
        halted = 1'b0;
        Start = 1'b0;
        return;
      end
      @(posedge Clock); #1;
    end
    Start = 1'b0;
  endtask

  task automatic halt_check(input string name);
    for (int i = 0; i < 4; i++) begin
      Start = 1'b1;
      check_output($sformatf("%s_halt_%0d", name, i), {24'd0, 1'b0, 1'b1, ill_seen});
      @(posedge Clock); #1;
      Start = 1'b0;
    end
  endtask

  initial begin
    logic        hit_halt;
    logic [31:0] rir;
    logic [4:0]  rop;
    int          rwait;

    do_reset();
    start_fetch();
    apply_stimulus("add", 32'h02920000, 0, -1, hit_halt);
    apply_stimulus("neg", 32'h82900000, 0, -1, hit_halt);
    apply_stimulus("mul_wait", 32'h70188000, 3, -1, hit_halt);
    apply_stimulus("illegal", 32'hA8000000, 0, -1, hit_halt);
    apply_stimulus("halt", 32'hD8000000, 1, -1, hit_halt);
    halt_check("halt");

    do_reset();
    start_fetch();
    apply_stimulus("add_abort", 32'h02920000, 0, 4, hit_halt);
    @(posedge Clock); #1;
    Clear = 1'b1;
    check_output("post_abort_idle", 27'd0);
    start_fetch();
    apply_stimulus("add_restart", 32'h02920000, 0, -1, hit_halt);

    for (int n = 0; n < 200; n++) begin
      rop = 5'($urandom_range(0, 31));
      rir = {rop, 27'($urandom)};
      rwait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      apply_stimulus($sformatf("rnd%0d_op%0d", n, rop), rir, rwait, -1, hit_halt);
      if (hit_halt) begin
        halt_check($sformatf("rnd%0d", n));
        do_reset();
        start_fetch();
      end
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
